// File: rtl/country_demand_detector_pkg.sv
// Shared types and default parameters for the country-road demand detector
// and the traffic-light controller that consumes its outputs.
package country_demand_detector_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        GREEN  = 2'b01,
        YELLOW = 2'b10
    } light_state_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        PULSE  = 2'b10,
        SERVED = 2'b11
    } det_state_e;

    localparam int unsigned DEF_DEBOUNCE  = 4;
    localparam int unsigned DEF_THRESH    = 3;
    localparam int unsigned DEF_MAX_WAIT  = 200;
    localparam int unsigned DEF_PULSE_LEN = 8;
    localparam int unsigned DEF_SERVE_TO  = 1024;
    localparam int unsigned DEF_CNT_W     = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/country_demand_detector_sense_debounce.sv
// Two-flop synchroniser plus disagreement-count debouncer for the loop sensor;
// emits the clean level and a one-cycle strobe on its rising transition.
module sense_debounce
    import country_demand_detector_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic car_sense,
    output logic sense_clean,
    output logic sense_rise
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE) + 1;

    if (DEBOUNCE < 1) begin : g_debounce_chk
        $error("DEBOUNCE must be at least 1");
    end

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            db_cnt      <= '0;
            sense_clean <= 1'b0;
            sense_rise  <= 1'b0;
        end else begin
            sync_q1    <= car_sense;
            sync_q2    <= sync_q1;
            sense_rise <= 1'b0;
            // Any agreement restarts the count, so short glitches never flip the level.
            if (sync_q2 == sense_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                sense_clean <= ~sense_clean;
                sense_rise  <= ~sense_clean;
                db_cnt      <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/country_demand_detector.sv
// Country-road demand detector: debounces the loop sensor, counts queued cars
// and issues one bounded service-request pulse per country-light service cycle.
module country_demand_detector
    import country_demand_detector_pkg::*;
#(
    parameter int unsigned DEBOUNCE  = DEF_DEBOUNCE,
    parameter int unsigned THRESH    = DEF_THRESH,
    parameter int unsigned MAX_WAIT  = DEF_MAX_WAIT,
    parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
    parameter int unsigned SERVE_TO  = DEF_SERVE_TO,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CAR_SENSE,
    input  logic [1:0]       COUNTRYLIGHT,
    output logic             COUNTRY_PULSE,
    output logic [CNT_W-1:0] COUNTRY_TRAFFIC,
    output logic             SENSE_CLEAN
);

    localparam int unsigned TMR_MAX = max_u(max_u(MAX_WAIT, PULSE_LEN), max_u(SERVE_TO, DEBOUNCE));
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    if (THRESH > (2 ** CNT_W) - 1) begin : g_thresh_chk
        $error("THRESH exceeds the COUNTRY_TRAFFIC range");
    end

    det_state_e       state;
    logic [1:0]       prev_light;
    logic             car_event;
    logic             green_entry_c;
    logic             seen_green;
    logic [TMR_W-1:0] wait_tmr;
    logic [TMR_W-1:0] pulse_tmr;
    logic [TMR_W-1:0] serve_tmr;

    sense_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_sense_debounce (
        .clk         (CLK),
        .rst_n       (RST_N),
        .car_sense   (CAR_SENSE),
        .sense_clean (SENSE_CLEAN),
        .sense_rise  (car_event)
    );

    assign green_entry_c = (prev_light != GREEN) && (COUNTRYLIGHT == GREEN);

    // Queue counter: green entry clears first, a coincident car then counts as one.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prev_light      <= RED;
            COUNTRY_TRAFFIC <= '0;
        end else begin
            prev_light <= COUNTRYLIGHT;
            if (green_entry_c) begin
                COUNTRY_TRAFFIC <= car_event ? CNT_W'(1) : '0;
            end else if (car_event && (COUNTRY_TRAFFIC != {CNT_W{1'b1}})) begin
                COUNTRY_TRAFFIC <= COUNTRY_TRAFFIC + CNT_W'(1);
            end
        end
    end

    // Request FSM: one pulse per service cycle, re-armed after GREEN then RED or a timeout.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= IDLE;
            COUNTRY_PULSE <= 1'b0;
            seen_green    <= 1'b0;
            wait_tmr      <= '0;
            pulse_tmr     <= '0;
            serve_tmr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (COUNTRY_TRAFFIC != '0) begin
                        state    <= WAIT;
                        wait_tmr <= '0;
                    end
                end
                WAIT: begin
                    wait_tmr <= wait_tmr + TMR_W'(1);
                    if ((COUNTRY_TRAFFIC >= CNT_W'(THRESH)) ||
                        (wait_tmr == TMR_W'(MAX_WAIT - 1))) begin
                        state         <= PULSE;
                        pulse_tmr     <= '0;
                        COUNTRY_PULSE <= 1'b1;
                    end else if (COUNTRY_TRAFFIC == '0) begin
                        state <= IDLE;
                    end
                end
                PULSE: begin
                    if (pulse_tmr == TMR_W'(PULSE_LEN - 1)) begin
                        state         <= SERVED;
                        COUNTRY_PULSE <= 1'b0;
                        serve_tmr     <= '0;
                        seen_green    <= 1'b0;
                    end else begin
                        pulse_tmr <= pulse_tmr + TMR_W'(1);
                    end
                end
                SERVED: begin
                    serve_tmr <= serve_tmr + TMR_W'(1);
                    if (green_entry_c) begin
                        seen_green <= 1'b1;
                    end
                    if ((seen_green && (COUNTRYLIGHT == RED)) ||
                        (serve_tmr == TMR_W'(SERVE_TO - 1))) begin
                        state      <= IDLE;
                        seen_green <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/country_demand_detector.md
Name: country_demand_detector

Overview:
- Upstream stage of the traffic-light controller.
- Conditions the raw country-road vehicle loop sensor: synchronise, then debounce.
- Counts waiting country cars and drives COUNTRY_TRAFFIC to the controller.
- Issues a bounded COUNTRY_PULSE whose falling edge is the controller's service request. Re-arms only after the country light has been served (GREEN, then back to RED).

Parameters:
- DEBOUNCE, 4: consecutive cycles the synchronised sensor must disagree with SENSE_CLEAN before SENSE_CLEAN flips (>=1).
- THRESH, 3: queued-car count that triggers an immediate pulse.
- MAX_WAIT, 200: cycles in WAIT before a pulse is forced, even if the count is below THRESH.
- PULSE_LEN, 8: cycles COUNTRY_PULSE is held high.
- SERVE_TO, 1024: SERVED-state timeout, in cycles.
- CNT_W, 4: width of COUNTRY_TRAFFIC.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous, active-low reset
- CAR_SENSE  in  1  raw loop sensor, asynchronous to CLK
- COUNTRYLIGHT  in  2  country light state from the controller: RED=00, GREEN=01, YELLOW=10
- COUNTRY_PULSE  out  1  service-request pulse; registered
- COUNTRY_TRAFFIC  out  CNT_W  queued country cars; registered, saturating
- SENSE_CLEAN  out  1  debounced sensor level

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - COUNTRY_PULSE=0, COUNTRY_TRAFFIC=0, SENSE_CLEAN=0.
  - Synchroniser flops and all timers = 0; FSM = IDLE.
  - Reset mid-pulse drops COUNTRY_PULSE on the same edge. The controller may see this as a falling edge; this is accepted.
- Synchroniser: 2 flops on CAR_SENSE.
- Debounce:
  - Counter increments while the synchronised level differs from SENSE_CLEAN; clears on agreement.
  - On reaching DEBOUNCE: SENSE_CLEAN toggles and the counter clears.
  - Latency: for CAR_SENSE held stable, SENSE_CLEAN changes DEBOUNCE+2 cycles after CAR_SENSE is first sampled.
  - Glitches shorter than DEBOUNCE cycles (post-sync) produce no change.
- Car event: single-cycle internal strobe on a SENSE_CLEAN 0->1 transition.
- GREEN entry: registered previous COUNTRYLIGHT != GREEN and current == GREEN.
- COUNTRY_TRAFFIC:
  - Increments one cycle after the car event.
  - Saturates at 2^CNT_W-1.
  - Cleared on GREEN entry.
  - Car event in the same cycle as GREEN entry: result = 1 (clear, then count).
- FSM, evaluated every cycle after reset:
  - IDLE: COUNTRY_TRAFFIC != 0 -> WAIT, wait timer = 0.
  - WAIT: wait timer increments.
    - COUNTRY_TRAFFIC >= THRESH or wait timer == MAX_WAIT-1 -> PULSE, pulse timer = 0.
    - COUNTRY_TRAFFIC returns to 0 (external GREEN clear) -> IDLE.
  - PULSE: COUNTRY_PULSE=1 for exactly PULSE_LEN cycles, then 0 on the edge entering SERVED.
  - SERVED: COUNTRY_PULSE=0; serve timer increments.
    - GREEN entry latches a "seen_green" flag.
    - seen_green and COUNTRYLIGHT==RED -> IDLE, flag cleared.
    - Serve timer == SERVE_TO-1 -> IDLE, flag cleared.
  - Car events in any state keep counting; the count is not lost on state changes.
- Exactly one COUNTRY_PULSE per service cycle. No re-trigger in PULSE or SERVED.
- Width rules:
  - Timers sized $clog2(max param)+1.
  - Comparisons unsigned; THRESH > 2^CNT_W-1 is a parameter error (elaboration assertion).

Decomposition:
- Shared package (same package the controller imports):
  - LIGHTSTATE enum {RED, GREEN, YELLOW}.
  - Detector state enum {IDLE, WAIT, PULSE, SERVED}.
  - Default parameter constants.
- One sub-module, sense_debounce: synchroniser plus debounce counter; outputs SENSE_CLEAN and the rise strobe; parameter DEBOUNCE.

Test Plan:
- Debounce latency: reset, then CAR_SENSE=1 held. SENSE_CLEAN=1 exactly 6 cycles after first sampling; COUNTRY_TRAFFIC=1 one cycle later. A 3-cycle glitch gives no change.
- Threshold trigger: 3 clean car events spaced 20 cycles apart. COUNTRY_PULSE rises the cycle after COUNTRY_TRAFFIC=3 and stays high for exactly 8 cycles.
- Timeout trigger: 1 car, COUNTRYLIGHT held RED. COUNTRY_PULSE rises 200 cycles after WAIT entry; COUNTRY_TRAFFIC stays 1.
- Service and re-arm: after the pulse, drive COUNTRYLIGHT RED->GREEN->YELLOW->RED.
  - COUNTRY_TRAFFIC=0 on GREEN entry.
  - FSM returns to IDLE on RED.
  - A new car produces a second pulse.
  - No pulse occurs during SERVED.
- Saturation and simultaneity: 20 car events give COUNTRY_TRAFFIC=15. A car event coinciding with GREEN entry gives COUNTRY_TRAFFIC=1.
- Reset mid-operation: assert RST_N=0 for 1 cycle at pulse cycle 4. Outputs go to 0/IDLE on that edge and no further pulse follows without new cars. SERVE_TO expiry without GREEN returns to IDLE.
